jtcop_ba_sched: RTL and testbench
=================================

# jtcop_ba_sched

Four-bank SDRAM access scheduler for the CoP game core. It sits between the per-bank slot multiplexers (bank 0 RAM/VRAM/ROM R/W, bank 1 sound, bank 2 BAC06 tiles, bank 3 objects) and the single-command SDRAM core. It picks one pending bank request at a time by round-robin, forwards the address, write data and mask, and routes the SDRAM core's handshake strobes back to the granted bank only. It also inserts periodic auto-refresh.

## Interface
Parameters:
- REF_CYCLES, 384: clk cycles between refresh requests; minimum 16.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- ba0_addr, ba1_addr, ba2_addr, ba3_addr  in  22  per-bank word address
- ba_rd  in  4  per-bank read request, level, held until the bank's ack
- ba_wr  in  1  bank 0 write request, level, held until ba_ack[0]
- ba0_din  in  16  bank 0 write data
- ba0_din_m  in  2  bank 0 write mask, active high = byte not written
- ba_ack  out  4  command accepted for bank i
- ba_dst  out  4  first data word for bank i is on data_read
- ba_dok  out  4  valid data word for bank i
- ba_rdy  out  4  access for bank i complete
- mem_req  out  1  access request to SDRAM core
- mem_we  out  1  access is a write
- mem_ba  out  2  SDRAM bank
- mem_addr  out  22  word address
- mem_din  out  16  write data
- mem_dqm  out  2  write byte mask
- mem_ref  out  1  refresh request
- mem_ack, mem_dst, mem_dok, mem_rdy  in  1 each  SDRAM core handshake
- busy  out  1  state is not IDLE

## Operation
- Bank 0 request is ba_rd[0] | ba_wr. A write is flagged when ba_wr=1 at grant. Banks 1–3 are read-only.
- States:
  - IDLE
  - ISSUE: mem_req or mem_ref high until mem_ack.
  - WAIT: waiting for mem_rdy.
  - REF: refresh issued and acknowledged, waiting for mem_rdy.
- In IDLE, priority order:
  1. ref_pending: go to ISSUE with mem_ref=1 and mem_req=0.
  2. Any pending bank: grant the first pending bank at or after the round-robin pointer (ptr, ptr+1, … mod 4). Set ptr = grant+1 mod 4. Go to ISSUE with mem_req=1.
- At grant, register the following. They stay stable until the return to IDLE:
  - mem_ba = grant
  - mem_addr = ba{grant}_addr
  - mem_we
  - mem_din = ba0_din for bank 0 writes, otherwise 0
  - mem_dqm = ba0_din_m for bank 0 writes, otherwise 0
- ISSUE:
  - On mem_ack, drop mem_req and mem_ref.
  - Next state: WAIT after a bank access, REF after a refresh.
  - If mem_rdy arrives together with mem_ack, go to IDLE directly.
- WAIT or REF: on mem_rdy, go to IDLE.
- Response routing is combinational:
  - ba_ack[g] = mem_ack while in ISSUE.
  - ba_dst[g], ba_dok[g], ba_rdy[g] = mem_dst, mem_dok, mem_rdy while in ISSUE or WAIT.
  - Here g is the latched grant, and routing applies only to a bank access, never a refresh.
  - All other bits are 0. No strobe ever reaches a non-granted bank.
- Request withdrawn after grant: ignored; the access completes.
- Refresh counter:
  - Free-running down-counter, reloaded with REF_CYCLES-1 when it reaches 0.
  - Reaching 0 sets ref_pending.
  - ref_pending clears when the refresh enters ISSUE.
  - An expiry while ref_pending is already set is lost; at most one refresh is queued.

## Timing
- Reset values, all asynchronous:
  - outputs 0
  - state IDLE, ptr 0
  - refresh counter REF_CYCLES-1, ref_pending 0
- Request high in IDLE at edge N: mem_req high from N+1.
- Minimum one IDLE cycle between accesses: mem_rdy at edge M gives IDLE at M+1, and the next mem_req at M+2.
- Acknowledgement latency and data latency are set by the SDRAM core. The scheduler adds no delay to strobes.
- Reset mid-access: immediate return to IDLE. mem_req, mem_ref and all ba_* strobes drop asynchronously.
- ptr wraps 3→0.

## Test plan
- Single read: ba_rd=4'b0100, ba2_addr=22'h10_0000.
  - mem_req one cycle later, with mem_ba=2, mem_addr=22'h10_0000, mem_we=0.
  - Core acks 2 cycles later → ba_ack=4'b0100 for one cycle.
  - dst/dok/rdy appear only on bit 2.
  - Then back to IDLE.
- Round-robin: ba_rd=4'b1111 held, each request dropped after its ack and re-raised one cycle later.
  - Grant order 0,1,2,3,0,1.
  - No bank is granted twice while another is pending.
- Bank 0 write: ba_wr=1, ba0_din=16'hA55A, ba0_din_m=2'b01.
  - mem_we=1, mem_din=16'hA55A, mem_dqm=2'b01.
  - ba_ack[0] pulse.
  - Change ba0_din after the grant → mem_din unchanged.
- Refresh: REF_CYCLES=16, continuous ba_rd[3].
  - mem_ref asserted once every 16 cycles on average.
  - A refresh never overlaps mem_req.
  - ba_* strobes stay 0 during the refresh handshake.
- Reset mid-access: rst_n low during WAIT.
  - All outputs are 0 in the same cycle.
  - After release, ba_rd=4'b0010 → first grant is bank 1 (ptr=0, bank 0 idle).
- Same-cycle mem_ack and mem_rdy: ba_ack[g] and ba_rdy[g] pulse together; the next cycle is IDLE.

Source files
------------

// File: rtl/jtcop_ba_sched.sv
// jtcop_ba_sched: four-bank SDRAM access scheduler for the CoP core.
// Picks one pending bank request at a time by round-robin and hands it to
// the single-command SDRAM core. It routes the core's strobes back to the
// granted bank only, and inserts periodic auto-refresh.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   ba0..ba3_addr [21:0]        per-bank word address
//   ba_rd [3:0], ba_wr          level requests (ba_wr is bank 0 only)
//   ba0_din [15:0], ba0_din_m   bank 0 write data / byte mask (1 = skip)
//   ba_ack/dst/dok/rdy [3:0]    per-bank strobes routed from the core
//   mem_req, mem_we, mem_ba, mem_addr, mem_din, mem_dqm, mem_ref
//                               command to the SDRAM core
//   mem_ack/dst/dok/rdy         SDRAM core handshake
//   busy                        scheduler is not idle
module jtcop_ba_sched #(
  parameter int unsigned REF_CYCLES = 384
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [21:0] ba0_addr,
  input  logic [21:0] ba1_addr,
  input  logic [21:0] ba2_addr,
  input  logic [21:0] ba3_addr,
  input  logic [3:0]  ba_rd,
  input  logic        ba_wr,
  input  logic [15:0] ba0_din,
  input  logic [1:0]  ba0_din_m,
  output logic [3:0]  ba_ack,
  output logic [3:0]  ba_dst,
  output logic [3:0]  ba_dok,
  output logic [3:0]  ba_rdy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  mem_ba,
  output logic [21:0] mem_addr,
  output logic [15:0] mem_din,
  output logic [1:0]  mem_dqm,
  output logic        mem_ref,
  input  logic        mem_ack,
  input  logic        mem_dst,
  input  logic        mem_dok,
  input  logic        mem_rdy,
  output logic        busy
);

  localparam int unsigned CW = $clog2(REF_CYCLES);
  localparam logic [CW-1:0] REF_LOAD = CW'(REF_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_REF} state_t;

  state_t         r_state;
  logic [1:0]     r_ptr;
  logic           r_isref;
  logic [CW-1:0]  r_refcnt;
  logic           r_refpend;
  logic           r_mem_req;
  logic           r_mem_ref;
  logic           r_mem_we;
  logic [1:0]     r_mem_ba;
  logic [21:0]    r_mem_addr;
  logic [15:0]    r_mem_din;
  logic [1:0]     r_mem_dqm;

  logic [3:0]     w_req;
  logic           w_found;
  logic [1:0]     w_gnt;
  logic [21:0]    w_addr;
  logic           w_wr0;
  logic           w_route;
  logic [3:0]     w_onehot;

  // Round-robin search: first pending bank at or after r_ptr (mod 4).
  always_comb begin
    w_req   = {ba_rd[3:1], ba_rd[0] | ba_wr};
    w_found = 1'b0;
    w_gnt   = r_ptr;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!w_found && w_req[r_ptr + 2'(i)]) begin
        w_found = 1'b1;
        w_gnt   = r_ptr + 2'(i);
      end
    end
  end

  always_comb begin
    case (w_gnt)
      2'd0:    w_addr = ba0_addr;
      2'd1:    w_addr = ba1_addr;
      2'd2:    w_addr = ba2_addr;
      default: w_addr = ba3_addr;
    endcase
    w_wr0 = (w_gnt == 2'd0) && ba_wr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_isref    <= 1'b0;
      r_refcnt   <= REF_LOAD;
      r_refpend  <= 1'b0;
      r_mem_req  <= 1'b0;
      r_mem_ref  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_ba   <= '0;
      r_mem_addr <= '0;
      r_mem_din  <= '0;
      r_mem_dqm  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_refpend) begin
            r_state   <= S_ISSUE;
            r_mem_ref <= 1'b1;
            r_isref   <= 1'b1;
            r_refpend <= 1'b0;
          end else if (w_found) begin
            r_state    <= S_ISSUE;
            r_mem_req  <= 1'b1;
            r_isref    <= 1'b0;
            r_ptr      <= w_gnt + 2'd1;
            r_mem_ba   <= w_gnt;
            r_mem_addr <= w_addr;
            r_mem_we   <= w_wr0;
            r_mem_din  <= w_wr0 ? ba0_din   : '0;
            r_mem_dqm  <= w_wr0 ? ba0_din_m : '0;
          end
        end
        S_ISSUE: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_mem_ref <= 1'b0;
            if (mem_rdy)      r_state <= S_IDLE;
            else if (r_isref) r_state <= S_REF;
            else              r_state <= S_WAIT;
          end
        end
        default: begin
          if (mem_rdy) r_state <= S_IDLE;
        end
      endcase
      // Placed after the FSM so an expiry on the same edge a refresh is
      // taken re-arms ref_pending instead of being swallowed by the clear.
      if (r_refcnt == '0) begin
        r_refcnt  <= REF_LOAD;
        r_refpend <= 1'b1;
      end else begin
        r_refcnt <= r_refcnt - 1'b1;
      end
    end
  end

  // Strobes are gated by state, so an asynchronous reset kills them at once.
  always_comb begin
    w_route  = ((r_state == S_ISSUE) || (r_state == S_WAIT)) && !r_isref;
    w_onehot = 4'b0001 << r_mem_ba;
    ba_ack   = (r_state == S_ISSUE && !r_isref && mem_ack) ? w_onehot : '0;
    ba_dst   = (w_route && mem_dst) ? w_onehot : '0;
    ba_dok   = (w_route && mem_dok) ? w_onehot : '0;
    ba_rdy   = (w_route && mem_rdy) ? w_onehot : '0;
  end

  assign mem_req  = r_mem_req;
  assign mem_ref  = r_mem_ref;
  assign mem_we   = r_mem_we;
  assign mem_ba   = r_mem_ba;
  assign mem_addr = r_mem_addr;
  assign mem_din  = r_mem_din;
  assign mem_dqm  = r_mem_dqm;
  assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_jtcop_ba_sched.sv
module tb_jtcop_ba_sched;

  localparam int unsigned REF = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [21:0] ba0_addr, ba1_addr, ba2_addr, ba3_addr;
  logic [3:0]  ba_rd;
  logic        ba_wr;
  logic [15:0] ba0_din;
  logic [1:0]  ba0_din_m;
  logic [3:0]  ba_ack, ba_dst, ba_dok, ba_rdy;
  logic        mem_req, mem_we, mem_ref, busy;
  logic [1:0]  mem_ba, mem_dqm;
  logic [21:0] mem_addr;
  logic [15:0] mem_din;
  logic        mem_ack, mem_dst, mem_dok, mem_rdy;

  jtcop_ba_sched #(.REF_CYCLES(REF)) dut (
    .clk(clk), .rst_n(rst_n),
    .ba0_addr(ba0_addr), .ba1_addr(ba1_addr), .ba2_addr(ba2_addr), .ba3_addr(ba3_addr),
    .ba_rd(ba_rd), .ba_wr(ba_wr), .ba0_din(ba0_din), .ba0_din_m(ba0_din_m),
    .ba_ack(ba_ack), .ba_dst(ba_dst), .ba_dok(ba_dok), .ba_rdy(ba_rdy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ba(mem_ba), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dqm(mem_dqm), .mem_ref(mem_ref),
    .mem_ack(mem_ack), .mem_dst(mem_dst), .mem_dok(mem_dok), .mem_rdy(mem_rdy),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          isref;
    logic [1:0]  ba;
    logic [21:0] addr;
    bit          we;
    logic [15:0] din;
    logic [1:0]  dqm;
  } exp_t;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  exp_t        q[$];
  logic [1:0]  glog[$];
  bit          force_slow = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  // ---------------- reference model ----------------
  // Transaction-level view: phase 0 idle, 1 command outstanding, 2 waiting
  // for completion. Grant = first requester scanning from ptr modulo 4.
  int unsigned m_phase = 0;
  bit          m_pend  = 1'b0;
  int unsigned m_cnt   = REF - 1;
  int unsigned m_ptr   = 0;
  exp_t        m_cur   = '{isref: 1'b0, ba: '0, addr: '0, we: 1'b0, din: '0, dqm: '0};

  initial begin
    logic [3:0] req;
    int         g;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_phase = 0; m_pend = 1'b0; m_cnt = REF - 1; m_ptr = 0;
        m_cur.isref = 1'b0;
        q.delete();
      end else begin
        req = {ba_rd[3:1], ba_rd[0] | ba_wr};
        case (m_phase)
          0: begin
            if (m_pend) begin
              m_pend = 1'b0;
              m_cur.isref = 1'b1;
              q.push_back(m_cur);
              m_phase = 1;
            end else if (req != 4'b0) begin
              g = -1;
              for (int k = 0; k < 4; k++)
                if (g < 0 && req[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
              m_cur.isref = 1'b0;
              m_cur.ba    = 2'(g);
              m_cur.addr  = (g == 0) ? ba0_addr : (g == 1) ? ba1_addr :
                            (g == 2) ? ba2_addr : ba3_addr;
              m_cur.we    = (g == 0) && ba_wr;
              m_cur.din   = m_cur.we ? ba0_din : 16'h0;
              m_cur.dqm   = m_cur.we ? ba0_din_m : 2'b0;
              q.push_back(m_cur);
              m_ptr   = (g + 1) % 4;
              m_phase = 1;
            end
          end
          1: if (mem_ack) m_phase = mem_rdy ? 0 : 2;
          default: if (mem_rdy) m_phase = 0;
        endcase
        if (m_cnt == 0) begin
          m_cnt = REF - 1;
          m_pend = 1'b1;
        end else begin
          m_cnt--;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic p_req, p_ref, bank;
    logic [3:0] oh;
    exp_t e;
    p_req = 1'b0; p_ref = 1'b0;
    forever begin
      @(negedge clk);
      bank = (m_phase != 0) && !m_cur.isref;
      oh   = 4'b0001 << m_cur.ba;
      chk("mem_req", mem_req, m_phase == 1 && !m_cur.isref);
      chk("mem_ref", mem_ref, m_phase == 1 && m_cur.isref);
      chk("busy", busy, m_phase != 0);
      chk("strobes", {ba_ack, ba_dst, ba_dok, ba_rdy},
          {(m_phase == 1 && bank && mem_ack) ? oh : 4'b0,
           (bank && mem_dst) ? oh : 4'b0,
           (bank && mem_dok) ? oh : 4'b0,
           (bank && mem_rdy) ? oh : 4'b0});
      if (mem_req && mem_ref) chk("req_ref_overlap", 1, 0);
      if ((mem_req && !p_req) || (mem_ref && !p_ref)) begin
        if (q.size() == 0) begin
          chk("unexpected_cmd", {mem_req, mem_ref}, 0);
        end else begin
          e = q.pop_front();
          chk("cmd_kind", mem_ref, e.isref);
          if (!e.isref) begin
            chk("mem_ba", mem_ba, e.ba);
            chk("mem_addr", mem_addr, e.addr);
            chk("mem_we", mem_we, e.we);
            chk("mem_din", mem_din, e.din);
            chk("mem_dqm", mem_dqm, e.dqm);
          end
        end
        if (mem_req) glog.push_back(mem_ba);
      end
      if (bank && mem_rdy) begin
        chk("din_hold", mem_din, m_cur.din);
        chk("addr_hold", mem_addr, m_cur.addr);
      end
      p_req = mem_req;
      p_ref = mem_ref;
    end
  end

  // ---------------- SDRAM core model ----------------
  initial begin
    int unsigned cst, ackdly, datdly;
    bit isread, same;
    cst = 0; ackdly = 0; datdly = 0; isread = 1'b0; same = 1'b0;
    mem_ack = 0; mem_dst = 0; mem_dok = 0; mem_rdy = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        mem_ack = 0; mem_dst = 0; mem_dok = 0; mem_rdy = 0;
        cst = 0;
      end else begin
        case (cst)
          0: begin
            mem_ack = 0; mem_dst = 0; mem_dok = 0; mem_rdy = 0;
            if (mem_req || mem_ref) begin
              isread = mem_req && !mem_we;
              ackdly = $urandom_range(0, 2);
              same   = !force_slow && ($urandom_range(0, 3) == 0);
              cst    = 1;
            end
          end
          1: begin
            if (ackdly > 0) ackdly--;
            else begin
              mem_ack = 1;
              if (same) begin
                mem_rdy = 1; mem_dst = isread; mem_dok = isread;
                cst = 5;
              end else begin
                datdly = $urandom_range(0, 2);
                cst = 2;
              end
            end
          end
          2: begin
            mem_ack = 0;
            if (datdly > 0) datdly--;
            else if (isread) begin mem_dst = 1; mem_dok = 1; cst = 3; end
            else begin mem_rdy = 1; cst = 5; end
          end
          3: begin mem_dst = 0; mem_dok = 1; cst = 4; end
          4: begin mem_dok = 0; mem_rdy = 1; cst = 5; end
          default: begin
            mem_ack = 0; mem_dst = 0; mem_dok = 0; mem_rdy = 0;
            cst = 0;
          end
        endcase
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_addr(input int b, input logic [21:0] a);
    case (b)
      0: ba0_addr = a;
      1: ba1_addr = a;
      2: ba2_addr = a;
      default: ba3_addr = a;
    endcase
  endtask

  task automatic wait_ack(input int b, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (ba_ack[b]) ok = 1'b1;
    end
    if (!ok) timeout("wait_ack");
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (m_phase == 0) ok = 1'b1;
    end
    if (!ok) timeout("wait_idle");
  endtask

  task automatic do_single(input int b, input logic [21:0] a, input bit wr,
                           input logic [15:0] d, input logic [1:0] m);
    bit ok;
    @(posedge clk); #1;
    set_addr(b, a);
    ba0_din = d; ba0_din_m = m;
    if (wr) ba_wr = 1'b1;
    else    ba_rd[b] = 1'b1;
    wait_ack(b, ok);
    @(posedge clk); #1;
    ba_rd = '0; ba_wr = 1'b0;
    ba0_din = ~d; ba0_din_m = ~m;   // must not reach mem_din/mem_dqm
    wait_idle();
  endtask

  initial begin
    logic [1:0]  exp_rr [6];
    logic [3:0]  acks, drop, pend;
    bit          wr0, ok;
    int unsigned gap [4];
    logic [21:0] ra;

    rst_n = 1'b0; ba_rd = '0; ba_wr = 1'b0; ba0_din = '0; ba0_din_m = '0;
    ba0_addr = '0; ba1_addr = '0; ba2_addr = '0; ba3_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {mem_req, mem_ref, mem_we, mem_ba, mem_addr, mem_din, mem_dqm,
                          ba_ack, ba_dst, ba_dok, ba_rdy, busy}, '0);
    rst_n = 1'b1;

    do_single(2, 22'h10_0000, 1'b0, 16'h0, 2'b00);
    do_single(0, 22'h00_1234, 1'b1, 16'hA55A, 2'b01);
    do_single(3, 22'h3F_FFFF, 1'b0, 16'h0, 2'b00);   // leaves ptr at 0

    // Round-robin: all four held, each dropped after ack, re-raised next cycle.
    glog.delete();
    ba0_addr = 22'h11; ba1_addr = 22'h22; ba2_addr = 22'h33; ba3_addr = 22'h44;
    @(posedge clk); #1;
    ba_rd = 4'b1111;
    drop = '0;
    for (int i = 0; i < 400 && glog.size() < 6; i++) begin
      @(negedge clk);
      acks = ba_ack;
      @(posedge clk); #1;
      ba_rd = (ba_rd & ~acks) | drop;
      drop  = acks;
    end
    ba_rd = '0;
    wait_idle();
    exp_rr = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    if (glog.size() < 6) timeout("rr_grants");
    else for (int i = 0; i < 6; i++) chk($sformatf("rr_order[%0d]", i), glog[i], exp_rr[i]);

    // Reset in the middle of a bank access.
    force_slow = 1'b1;
    @(posedge clk); #1;
    ba1_addr = 22'h2A_AAAA;
    ba_rd = 4'b0010;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (m_phase == 2 && !m_cur.isref) ok = 1'b1;
    end
    if (!ok) timeout("reach_wait");
    #2 rst_n = 1'b0;
    #1;
    chk("reset_mid_access", {mem_req, mem_ref, mem_we, mem_ba, mem_addr, mem_din, mem_dqm,
                             ba_ack, ba_dst, ba_dok, ba_rdy, busy}, '0);
    ba_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    force_slow = 1'b0;
    glog.delete();
    ba_rd = 4'b0010;
    wait_ack(1, ok);
    @(posedge clk); #1;
    ba_rd = '0;
    wait_idle();
    if (glog.size() == 0) timeout("post_reset_grant");
    else chk("post_reset_grant", glog[0], 2'd1);

    // Randomised traffic: all banks, random gaps, bank 0 mixes reads/writes.
    pend = '0; wr0 = 1'b0;
    for (int b = 0; b < 4; b++) gap[b] = $urandom_range(0, 3);
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      acks = ba_ack;
      @(posedge clk); #1;
      for (int b = 0; b < 4; b++) begin
        if (pend[b]) begin
          if (acks[b]) begin
            pend[b] = 1'b0;
            gap[b]  = $urandom_range(0, 3);
          end
        end else if (gap[b] == 0) begin
          pend[b] = 1'b1;
          ra = 22'($urandom);
          set_addr(b, ra);
          if (b == 0) begin
            wr0 = $urandom_range(0, 1) == 1;
            ba0_din_m = 2'($urandom);
          end
        end else begin
          gap[b]--;
        end
      end
      if (!pend[0]) ba0_din = 16'($urandom);
      else if (acks[0] == 1'b0 && m_phase != 0 && m_cur.ba == 2'd0) ba0_din = 16'($urandom);
      ba_rd = {pend[3:1], pend[0] && !wr0};
      ba_wr = pend[0] && wr0;
    end
    ba_rd = '0; ba_wr = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    chk("queue_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
